neuron_accumulate_stage: RTL and testbench

- Consumer end of the parameter-fetch handshake. Accepts (neuronInput, neuronWeight) pairs offered with paramsReady, and returns readyNextParam to pace the fetch stage.
- Performs a signed fixed-point multiply-accumulate over numInputs pairs.
- Shifts, saturates and optionally rectifies the sum, then presents one neuron result downstream under a valid/ready handshake.
- Sits between the parameter fetch stage and the neuron output writeback.

---
 rtl/neuron_accumulate_stage.sv | 149 ++++++++++++++
 tb/tb_neuron_accumulate_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_accumulate_stage.sv
// Neuron accumulate stage: consumes (input, weight) pairs from the fetch
// stage, runs a signed Q-format multiply-accumulate, then shifts, saturates
// and optionally rectifies the sum before handing one result downstream.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; no pairs accepted, no result offered
// ACCUM  | readyNextParam high; each accepted pair is multiplied and summed
// FINISH | one cycle: scale, saturate and rectify the sum into outData
// DONE   | outValid high with outData stable until outReady
module neuron_accumulate_stage #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 48,
    parameter int RELU      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       numInputs,
    input  logic [DATA_W-1:0] neuronInput,
    input  logic [DATA_W-1:0] neuronWeight,
    input  logic              paramsReady,
    output logic              readyNextParam,
    output logic [DATA_W-1:0] outData,
    output logic              outValid,
    input  logic              outReady,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                     state;
    state_t                     next_state;
    logic signed [ACC_W-1:0]    acc;
    logic [15:0]                count;
    logic [15:0]                num_latched;
    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    product_ext;
    logic signed [ACC_W-1:0]    shifted;
    logic [DATA_W-1:0]          result;
    logic                       xfer;
    logic                       last_xfer;

    assign product     = $signed(neuronInput) * $signed(neuronWeight);
    assign product_ext = {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};
    assign xfer        = (state == ACCUM) && paramsReady;
    assign last_xfer   = xfer && (count == num_latched - 16'd1);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        next_state     = state;
        readyNextParam = 1'b0;
        outValid       = 1'b0;
        busy           = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = (numInputs == 16'd0) ? FINISH : ACCUM;
                end
            end
            ACCUM: begin
                readyNextParam = 1'b1;
                if (last_xfer) begin
                    next_state = FINISH;
                end
            end
            FINISH: begin
                next_state = DONE;
            end
            DONE: begin
                outValid = 1'b1;
                if (outReady) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Scale the sum back to the Q format, clamp to the word range, rectify.
    always_comb begin
        shifted = acc >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[DATA_W-1:0];
        end else begin
            result = shifted[DATA_W-1:0];
        end
        if ((RELU == 1) && result[DATA_W-1]) begin
            result = '0;
        end
    end

    // Accumulator, pair counter, latched length and registered result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc         <= '0;
            count       <= '0;
            num_latched <= '0;
            outData     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc         <= '0;
                        count       <= '0;
                        num_latched <= numInputs;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc   <= acc + product_ext;
                        count <= count + 16'd1;
                    end
                end
                FINISH: begin
                    outData <= result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_accumulate_stage.sv
// Directed bench for neuron_accumulate_stage: one RELU=1 and one RELU=0
// instance share all stimulus so the rectified and raw results can be
// compared against hand-computed Q8.8 values side by side.
module tb_neuron_accumulate_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_inputs;
    logic [15:0] neuron_input;
    logic [15:0] neuron_weight;
    logic        params_ready;
    logic        out_ready;

    logic        r1_ready, r1_valid, r1_busy;
    logic [15:0] r1_data;
    logic        r0_ready, r0_valid, r0_busy;
    logic [15:0] r0_data;

    int tests = 0;
    int fails = 0;
    int xfers = 0;

    always #5 clk = ~clk;

    neuron_accumulate_stage #(.RELU(1)) dut_r1 (
        .clk(clk), .rst(rst), .start(start), .numInputs(num_inputs),
        .neuronInput(neuron_input), .neuronWeight(neuron_weight),
        .paramsReady(params_ready), .readyNextParam(r1_ready),
        .outData(r1_data), .outValid(r1_valid), .outReady(out_ready),
        .busy(r1_busy)
    );

    neuron_accumulate_stage #(.RELU(0)) dut_r0 (
        .clk(clk), .rst(rst), .start(start), .numInputs(num_inputs),
        .neuronInput(neuron_input), .neuronWeight(neuron_weight),
        .paramsReady(params_ready), .readyNextParam(r0_ready),
        .outData(r0_data), .outValid(r0_valid), .outReady(out_ready),
        .busy(r0_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: pulse start for one edge, then scramble numInputs.
    task automatic start_neuron(input logic [15:0] n);
        start      = 1'b1;
        num_inputs = n;
        @(negedge clk);
        start      = 1'b0;
        num_inputs = 16'hFFFF;
    endtask

    // Called at a negedge: offer one pair for the coming edge.
    task automatic pair(input logic [15:0] a, input logic [15:0] b,
                        input logic v);
        neuron_input  = a;
        neuron_weight = b;
        params_ready  = v;
        if (r1_ready && v) xfers++;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!r1_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, {31'd0, r1_valid}, 32'd1);
    endtask

    task automatic run_const(input logic [15:0] n, input logic [15:0] a,
                             input logic [15:0] b, input string tag);
        int guard = 0;
        xfers = 0;
        start_neuron(n);
        while (r1_ready && guard < 20) begin
            pair(a, b, 1'b1);
            guard++;
        end
        params_ready = 1'b0;
        wait_valid(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b0;
        start         = 1'b0;
        num_inputs    = 16'd0;
        neuron_input  = 16'd0;
        neuron_weight = 16'd0;
        params_ready  = 1'b0;
        out_ready     = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_ready", {31'd0, r1_ready}, 32'd0);
        check_val("rst_valid", {31'd0, r1_valid}, 32'd0);
        check_val("rst_busy",  {31'd0, r1_busy},  32'd0);
        check_val("rst_data",  {16'd0, r1_data},  32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Basic MAC: 3 x (1.5 * 2.0) = 9.0
        xfers        = 0;
        params_ready = 1'b1;
        start_neuron(16'd3);
        check_val("t1_ready", {31'd0, r1_ready}, 32'd1);
        check_val("t1_busy",  {31'd0, r1_busy},  32'd1);
        repeat (3) pair(16'h0180, 16'h0200, 1'b1);
        check_val("t1_xfers", xfers, 32'd3);
        check_val("t1_fin_ready", {31'd0, r1_ready}, 32'd0);
        check_val("t1_fin_valid", {31'd0, r1_valid}, 32'd0);
        @(negedge clk);
        check_val("t1_lat_valid", {31'd0, r1_valid}, 32'd1);
        check_val("t1_done_ready", {31'd0, r1_ready}, 32'd0);
        check_val("t1_data_r1", {16'd0, r1_data}, 32'h0900);
        check_val("t1_data_r0", {16'd0, r0_data}, 32'h0900);
        @(negedge clk);
        check_val("t1_valid_drop", {31'd0, r1_valid}, 32'd0);
        check_val("t1_idle_busy",  {31'd0, r1_busy},  32'd0);

        // Negative sum: 3 x (1.0 * -1.0) = -3.0
        run_const(16'd3, 16'h0100, 16'hFF00, "t2_valid");
        check_val("t2_xfers", xfers, 32'd3);
        check_val("t2_data_r0", {16'd0, r0_data}, 32'hFD00);
        check_val("t2_data_r1", {16'd0, r1_data}, 32'h0000);
        @(negedge clk);

        // Positive saturation
        run_const(16'd3, 16'h7FFF, 16'h7FFF, "t3a_valid");
        check_val("t3a_data_r0", {16'd0, r0_data}, 32'h7FFF);
        check_val("t3a_data_r1", {16'd0, r1_data}, 32'h7FFF);
        @(negedge clk);

        // Negative saturation
        run_const(16'd3, 16'h8000, 16'h7FFF, "t3b_valid");
        check_val("t3b_data_r0", {16'd0, r0_data}, 32'h8000);
        check_val("t3b_data_r1", {16'd0, r1_data}, 32'h0000);
        @(negedge clk);

        // Stalls carry garbage data that must not be summed: 1+2+3 = 6.0
        out_ready = 1'b0;
        xfers     = 0;
        start_neuron(16'd3);
        pair(16'h0100, 16'h0100, 1'b1);
        pair(16'h7FFF, 16'h7FFF, 1'b0);
        pair(16'h7FFF, 16'h7FFF, 1'b0);
        pair(16'h0200, 16'h0100, 1'b1);
        pair(16'h0300, 16'h0100, 1'b1);
        params_ready = 1'b0;
        check_val("t4_xfers", xfers, 32'd3);
        check_val("t4_fin_ready", {31'd0, r1_ready}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check_val("t4_hold_valid", {31'd0, r1_valid}, 32'd1);
            check_val("t4_hold_data",  {16'd0, r0_data},  32'h0600);
            start      = 1'b1;
            num_inputs = 16'd1;
            @(negedge clk);
        end
        check_val("t4_hold_valid_end", {31'd0, r1_valid}, 32'd1);
        check_val("t4_hold_data_r1", {16'd0, r1_data}, 32'h0600);
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("t4_release_valid", {31'd0, r1_valid}, 32'd0);
        check_val("t4_release_busy",  {31'd0, r1_busy},  32'd0);
        @(negedge clk);
        check_val("t4_start_ignored", {31'd0, r1_busy}, 32'd0);

        // Reset mid-ACCUM, then a fresh single-pair neuron
        xfers = 0;
        start_neuron(16'd3);
        pair(16'h1000, 16'h0100, 1'b1);
        check_val("t6_mid_ready", {31'd0, r1_ready}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check_val("t6_rst_ready", {31'd0, r1_ready}, 32'd0);
        check_val("t6_rst_busy",  {31'd0, r1_busy},  32'd0);
        check_val("t6_rst_valid", {31'd0, r1_valid}, 32'd0);
        check_val("t6_rst_data",  {16'd0, r0_data},  32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_const(16'd1, 16'h0100, 16'h0100, "t6_valid");
        check_val("t6_xfers", xfers, 32'd1);
        check_val("t6_data_r1", {16'd0, r1_data}, 32'h0100);
        check_val("t6_data_r0", {16'd0, r0_data}, 32'h0100);
        @(negedge clk);

        // Zero inputs: straight to FINISH, never ready for params
        params_ready = 1'b1;
        start_neuron(16'd0);
        check_val("t5_ready",  {31'd0, r1_ready}, 32'd0);
        check_val("t5_valid0", {31'd0, r1_valid}, 32'd0);
        check_val("t5_busy",   {31'd0, r1_busy},  32'd1);
        @(negedge clk);
        check_val("t5_valid",  {31'd0, r1_valid}, 32'd1);
        check_val("t5_ready2", {31'd0, r1_ready}, 32'd0);
        check_val("t5_data_r1", {16'd0, r1_data}, 32'h0000);
        check_val("t5_data_r0", {16'd0, r0_data}, 32'h0000);
        @(negedge clk);
        check_val("t5_valid_drop", {31'd0, r1_valid}, 32'd0);
        params_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
